// File: rtl/u_fetch.sv
// Instruction fetch sequencer: PC, one-at-a-time req/ack memory fetch, valid/ready to decode, redirects.
// Optional halt-on-OpCode-6'b111111 behaviour is enabled by defining FETCH_HALT_EN.
module u_fetch #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              im_req,
  output logic [ADDR_W-1:0] im_addr,
  input  logic              im_ack,
  input  logic [31:0]       im_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [5:0]        OpCode,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_DRAIN
`ifdef FETCH_HALT_EN
    , S_HALT
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        inst_q, inst_d;
  logic [ADDR_W-1:0]  inst_pc_q, inst_pc_d;

  logic [ADDR_W-1:0]  redirTgt;
  logic [ADDR_W-1:0]  pcInc;
  logic               isHaltOp;
  logic               unusedRedirLsb;

  assign redirTgt       = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign pcInc          = pc_q + ADDR_W'(4);
  assign unusedRedirLsb = ^redirect_pc[1:0];

`ifdef FETCH_HALT_EN
  assign isHaltOp = (inst_q[31:26] == 6'b111111);
`else
  assign isHaltOp = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // An ack that coincides with a redirect drops the data and re-requests at the target.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_REQ;
      S_REQ: begin
        if (im_ack) begin
          state_d = redirect ? S_REQ : S_HOLD;
        end else if (redirect) begin
          state_d = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          state_d = S_REQ;
        end else if (inst_ready) begin
`ifdef FETCH_HALT_EN
          state_d = isHaltOp ? S_HALT : S_REQ;
`else
          state_d = S_REQ;
`endif
        end
      end
      S_DRAIN: begin
        if (im_ack) begin
          state_d = S_REQ;
        end
      end
`ifdef FETCH_HALT_EN
      S_HALT: begin
        if (redirect) begin
          state_d = S_REQ;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    im_req     = (state_q == S_REQ) || (state_q == S_DRAIN);
    inst_valid = (state_q == S_HOLD);
`ifdef FETCH_HALT_EN
    halted     = (state_q == S_HALT);
`else
    halted     = 1'b0;
`endif
    im_addr    = addr_q;
    inst       = inst_q;
    OpCode     = inst_q[31:26];
    inst_pc    = inst_pc_q;
  end

  // The request address is frozen while draining so the outstanding access stays consistent.
  always_comb begin
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    if ((state_q == S_REQ) && im_ack && !redirect) begin
      inst_d    = im_rdata;
      inst_pc_d = pcInc;
      pc_d      = pcInc;
    end
    if (redirect) begin
      pc_d = redirTgt;
    end
    addr_d = (state_d == S_DRAIN) ? addr_q : pc_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      addr_q    <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

endmodule

// File: doc/u_fetch.md
# u_fetch

Instruction fetch sequencer that produces the instruction words, and thus the `OpCode` field, consumed by the main control unit's decode stage. It holds the program counter and issues one request at a time to instruction memory over a req/ack handshake. It presents each returned word to decode over a valid/ready handshake. It accepts branch/jump redirects from the execute stage.

## Interface
- `ADDR_W`, 32, PC and instruction-memory byte-address width
- `RESET_PC`, 0, PC value loaded on reset (word aligned)

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `im_req`  out  1  instruction-memory request, registered
- `im_addr`  out  ADDR_W  request address = current PC, bits [1:0] always 0
- `im_ack`  in  1  one-cycle pulse; `im_rdata` valid in the same cycle; only meaningful while `im_req`=1
- `im_rdata`  in  32  instruction word
- `inst_valid`  out  1  `inst` holds an instruction for decode
- `inst_ready`  in  1  decode accepts `inst` this cycle
- `inst`  out  32  registered instruction word
- `OpCode`  out  6  `inst[31:26]`, combinational from `inst`
- `inst_pc`  out  ADDR_W  address of `inst` plus 4 (used for the branch base)
- `redirect`  in  1  one-cycle pulse: load a new PC
- `redirect_pc`  in  ADDR_W  target; bits [1:0] ignored and forced to 0
- `halted`  out  1  fetch stopped (see Configuration)

## Operation
- States:
  - S_IDLE: post-reset, one cycle.
  - S_REQ: `im_req`=1, waiting for ack.
  - S_HOLD: `inst_valid`=1.
  - S_DRAIN: request outstanding, returned data to be discarded.
  - S_HALT: only with the macro.
- Reset values:
  - `pc`=`RESET_PC`, state S_IDLE.
  - `im_req`=0, `inst_valid`=0, `inst`=0, `inst_pc`=0, `halted`=0.
  - `im_addr` follows `pc`.
- S_IDLE → S_REQ unconditionally.
- S_REQ:
  - `im_req` stays high until `im_ack`.
  - On ack: `inst`←`im_rdata`, `inst_pc`←`pc`+4, `pc`←`pc`+4, `inst_valid`←1, `im_req`←0, go to S_HOLD.
- S_HOLD:
  - `inst`, `OpCode` and `inst_pc` are stable while `inst_valid`=1 and `inst_ready`=0.
  - On `inst_ready`: `inst_valid`←0, `im_req`←1, go to S_REQ.
- Redirect:
  - `pc`←{`redirect_pc`[ADDR_W-1:2],2'b00}. A redirect always wins over `pc`+4.
  - In S_HOLD: `inst_valid`←0 and go to S_REQ. If `inst_ready` is high in the same cycle, the handshake still counts as accepted.
  - In S_REQ without `im_ack`: go to S_DRAIN, keep `im_req`=1 and `im_addr` unchanged until ack, drop the data, then go to S_REQ at the new PC.
  - In S_REQ with `im_ack` in the same cycle: data dropped, `inst_valid` stays 0, `im_req`←1 next cycle at the new PC.
  - In S_IDLE: `pc`←target, then continue to S_REQ.
  - Redirect during S_DRAIN: only the target is updated.
- PC arithmetic is modulo 2^ADDR_W; `pc`+4 at 0xFFFFFFFC wraps to 0.
- At most one outstanding memory request; `im_ack` while `im_req`=0 is ignored.
- Reset mid-operation: all state returns to reset values immediately; any pending ack is ignored.

## Timing
- `im_req` and `im_addr` are registered; the earliest ack is in the first cycle `im_req`=1, giving `inst_valid` in the next cycle.
- Minimum fetch period: 2 cycles per instruction (ack in cycle N, `inst_valid` in N+1, ready in N+1, `im_req` in N+2).
- First `im_req` appears 2 cycles after `reset` deasserts (S_IDLE, then S_REQ).
- Redirect-to-request latency: 1 cycle, unless draining.
- `OpCode` has zero latency from `inst`.

## Configuration
- `FETCH_HALT_EN` defined:
  - An instruction with `OpCode`=6'b111111 is fetched and presented normally.
  - After its decode handshake, the block enters S_HALT with `halted`=1, `im_req`=0 and `inst_valid`=0.
  - Only `redirect` (→ S_REQ at the target, `halted`←0) or `reset` leaves S_HALT.
- `FETCH_HALT_EN` undefined: 6'b111111 is an ordinary instruction, S_HALT does not exist, `halted` is tied to 0.

## Test plan
- Reset release, memory acks on the first request cycle, `inst_ready`=1: addresses 0,4,8,12 are issued; `inst_valid` rises every 2 cycles; `OpCode` matches `im_rdata[31:26]` (e.g. 0x8C010004 → 6'b100011).
- Ack delayed 3 cycles and `inst_ready` held low 4 cycles: `im_req` stays high through the wait; `inst`/`inst_pc` stay stable; no new request is issued until the handshake.
- `redirect`=1, `redirect_pc`=0x43 while a request is outstanding: the old ack data is dropped, `inst_valid` stays 0, and the next `im_addr`=0x40.
- `redirect` coincident with `im_ack`, and separately coincident with an S_HOLD handshake: no stale instruction is presented; the next request goes to the redirect target.
- PC=0xFFFFFFFC fetch: the next `im_addr`=0x00000000; `inst_pc`=0.
- With `FETCH_HALT_EN`, word 0xFC000000 is accepted: `halted`=1 and no `im_req` for 20 cycles. A redirect to 0x100 clears `halted` and fetches 0x100. Without the macro, the next address is fetched normally.
